// File: rtl/div_int_seq_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding and default width.
package div_int_seq_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_SIGN = 3'd3,
    S_WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/div_int_seq_dp.sv
// Restoring-division datapath: magnitude registers, iteration counter and the final sign fix.
// The first quotient step is folded into the load cycle, so only N-1 iteration cycles follow.
module div_int_seq_dp
  import div_int_seq_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_i,
  input  logic                skip_i,
  input  logic                iter_i,
  input  logic                sign_i,
  input  logic signed [N-1:0] x_i,
  input  logic signed [N-1:0] y_i,
  output logic                last_o,
  output logic signed [N-1:0] q_o,
  output logic signed [N-1:0] r_o
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  function automatic logic [N-1:0] add_n(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin);
    return a + b + {{(N-1){1'b0}}, cin};
  endfunction

  function automatic logic [N-1:0] abs_nat(input logic [N-1:0] a);
    return a[N-1] ? add_n(~a, '0, 1'b1) : a;
  endfunction

  function automatic logic comp_nat(input logic [N:0] a, input logic [N:0] b);
    return a >= b;
  endfunction

  logic [N-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sx_q, sx_d, sy_q, sy_d;
  logic [N-1:0]  qo_q, qo_d, ro_q, ro_d;

  logic [N-1:0]  abs_x, abs_y, r_src, q_src, d_src, r_step, q_step;
  logic [N:0]    t;
  logic          ge;

  assign abs_x = abs_nat(x_i);
  assign abs_y = abs_nat(y_i);

  // One restoring step; during load it starts from R=0, Q=|x|, D=|y|.
  always_comb begin
    r_src  = load_i ? '0 : rem_q;
    q_src  = load_i ? abs_x : quo_q;
    d_src  = load_i ? abs_y : dvs_q;
    t      = {r_src, q_src[N-1]};
    ge     = comp_nat(t, {1'b0, d_src});
    r_step = ge ? add_n(t[N-1:0], ~d_src, 1'b1) : t[N-1:0];
    q_step = {q_src[N-2:0], ge};
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    qo_d  = qo_q;
    ro_d  = ro_q;
    if (load_i) begin
      dvs_d = abs_y;
      sx_d  = x_i[N-1];
      sy_d  = y_i[N-1];
      if (skip_i) begin
        quo_d = '0;
        rem_d = abs_x;
        cnt_d = '0;
      end else begin
        quo_d = q_step;
        rem_d = r_step;
        cnt_d = CW'(N-2);
      end
    end else if (iter_i) begin
      quo_d = q_step;
      rem_d = r_step;
      cnt_d = cnt_q - CW'(1);
    end
    if (sign_i) begin
      qo_d = (sx_q ^ sy_q) ? add_n(~quo_q, '0, 1'b1) : quo_q;
      ro_d = sx_q ? add_n(~rem_q, '0, 1'b1) : rem_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
      qo_q  <= '0;
      ro_q  <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      qo_q  <= qo_d;
      ro_q  <= ro_d;
    end
  end

  assign last_o = (cnt_q == '0);
  assign q_o    = qo_q;
  assign r_o    = ro_q;

endmodule

// File: rtl/div_int_seq.sv
// Sequential signed divider with soc/eoc handshake; FSM and operand capture live here.
// Define DIV0_CHECK_EN to short-circuit y=0 and flag it on div0.
module div_int_seq
  import div_int_seq_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                soc,
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] y,
  output logic                eoc,
  output logic signed [N-1:0] q,
  output logic signed [N-1:0] r,
  output logic                ow,
  output logic                div0
);

  localparam logic signed [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t state_q, state_d;
  logic signed [N-1:0] x_q, y_q;
  logic ow_q, ow_d;
  logic accept, load, skip, iter, sign, last;

  always_comb begin
    state_d = state_q;
    eoc     = 1'b0;
    accept  = 1'b0;
    load    = 1'b0;
    skip    = 1'b0;
    iter    = 1'b0;
    sign    = 1'b0;
    case (state_q)
      S_IDLE: begin
        eoc = 1'b1;
        if (soc) begin
          accept  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_ITER;
`ifdef DIV0_CHECK_EN
        if (y_q == '0) begin
          skip    = 1'b1;
          state_d = S_SIGN;
        end
`endif
      end
      S_ITER: begin
        iter = 1'b1;
        if (last) state_d = S_SIGN;
      end
      S_SIGN: begin
        sign    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        eoc = 1'b1;
        // Held soc must not retrigger; wait for it to drop.
        if (!soc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ow_d = sign ? ((x_q == MIN_NEG) && (y_q == '1)) : ow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ow_q    <= ow_d;
      if (accept) begin
        x_q <= x;
        y_q <= y;
      end
    end
  end

`ifdef DIV0_CHECK_EN
  logic div0_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       div0_q <= 1'b0;
    else if (accept) div0_q <= 1'b0;
    else if (sign)   div0_q <= (y_q == '0);
  end
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

  div_int_seq_dp #(.N(N)) u_dp (
    .clock  (clock),
    .reset  (reset),
    .load_i (load),
    .skip_i (skip),
    .iter_i (iter),
    .sign_i (sign),
    .x_i    (x_q),
    .y_i    (y_q),
    .last_o (last),
    .q_o    (q),
    .r_o    (r)
  );

  assign ow = ow_q;

endmodule
